// File: rtl/timer_rr_sched_pkg.sv
// rtl/timer_rr_sched_pkg.sv - shared state encodings and default widths for the timer scheduler
package timer_rr_sched_pkg;

  localparam int TMR_CNT_W = 8;
  localparam int TMR_N_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/timer_mod_cnt.sv
// rtl/timer_mod_cnt.sv - modulo tick counter that counts 1..term and holds at term
module timer_mod_cnt
  import timer_rr_sched_pkg::*;
#(
  parameter int CNT_W = TMR_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] cnt,
  output logic             max_tick
);

  assign max_tick = (cnt == term);

  // Count up while enabled, stopping at term so the value never wraps past it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !max_tick) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_rr_sched.sv
// rtl/timer_rr_sched.sv - round-robin scheduler sharing one tick counter; TIMER_SCHED_ABORT_EN enables abort on dropped request
module timer_rr_sched
  import timer_rr_sched_pkg::*;
#(
  parameter int N_REQ = TMR_N_REQ,
  parameter int CNT_W = TMR_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] req_len,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [CNT_W-1:0]       cnt_val
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] len;
  logic [IDX_W-1:0] pick_idx;
  logic [CNT_W-1:0] pick_len;
  logic             pick_valid;
  logic [IDX_W-1:0] ptr_next;
  logic             abort;
  logic             cnt_clr;
  logic             cnt_en;
  logic             max_tick;

  // Round-robin pick: first request at or above the pointer, else the first one below it.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_len   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_valid && req[k] && (IDX_W'(k) >= ptr)) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(k);
        pick_len   = req_len[k*CNT_W +: CNT_W];
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_valid && req[k]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(k);
        pick_len   = req_len[k*CNT_W +: CNT_W];
      end
    end
  end

  assign ptr_next = (pick_idx == IDX_W'(N_REQ-1)) ? '0 : pick_idx + 1'b1;

`ifdef TIMER_SCHED_ABORT_EN
  assign abort = ((state == ST_LOAD) || (state == ST_RUN)) && !req[idx];
`else
  assign abort = 1'b0;
`endif

  // The counter restarts on every new grant and on abort; it only advances while the owner holds it.
  assign cnt_clr = ((state == ST_IDLE) && pick_valid) || abort;
  assign cnt_en  = ((state == ST_LOAD) || (state == ST_RUN)) && !abort;
  assign busy    = (state != ST_IDLE);

  timer_mod_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .term     (len),
    .cnt      (cnt_val),
    .max_tick (max_tick)
  );

  // Scheduler FSM with registered grant/done so owners see clean, glitch-free handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
      idx   <= '0;
      len   <= '0;
      grant <= '0;
      done  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done  <= '0;
          grant <= '0;
          if (pick_valid) begin
            idx   <= pick_idx;
            len   <= pick_len;
            ptr   <= ptr_next;
            grant <= ONE_HOT0 << pick_idx;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            grant <= '0;
            state <= ST_IDLE;
          end else if (len != '0) begin
            state <= ST_RUN;
          end else begin
            grant <= '0;
            done  <= ONE_HOT0 << idx;
            state <= ST_DONE;
          end
        end
        ST_RUN: begin
          if (abort) begin
            grant <= '0;
            state <= ST_IDLE;
          end else if (max_tick) begin
            grant <= '0;
            done  <= ONE_HOT0 << idx;
            state <= ST_DONE;
          end
        end
        default: begin
          done  <= '0;
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_rr_sched.sv
// tb/tb_timer_rr_sched.sv - self-checking bench for timer_rr_sched with a done-pulse scoreboard
module tb_timer_rr_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_len;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  cnt_val;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;
  int   cyc;

  timer_rr_sched #(
    .N_REQ(4),
    .CNT_W(8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .req_len (req_len),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .cnt_val (cnt_val)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_all_len(input logic [7:0] v);
    for (int i = 0; i < 4; i++) req_len[i*8 +: 8] = v;
  endtask

  task automatic test_reset();
    int c;
    bit seen;
    exp_t e;
    logic [3:0] exp_oh;
    @(negedge clk);
    req = 4'hF;
    set_all_len(8'd1);
    reset = 1'b1;
    #1;
    total++; if (grant !== 4'h0) begin bad++; $display("FAIL reset_grant got=%h want=0", grant); end
    total++; if (done !== 4'h0) begin bad++; $display("FAIL reset_done got=%h want=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (cnt_val !== 8'h0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt_val); end
    @(negedge clk);
    reset = 1'b0;
    c = cyc;
    sb.push_back('{0, c + 3});
    @(negedge clk);
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b want=0001", grant); end
    req = 4'b0001;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (done !== 4'h0) begin
        seen = 1'b1;
        e = sb.pop_front();
        exp_oh = 4'b0001 << e.idx;
        total++;
        if (done !== exp_oh || cyc != e.cyc) begin
          bad++; $display("FAIL reset_done_pulse got=%b@%0d want=%b@%0d", done, cyc, exp_oh, e.cyc);
        end
        req = 4'h0;
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL reset_done_timeout got=none want=done"); end
  endtask

  task automatic test_single();
    int c, busy_n, done_n;
    bit ok;
    exp_t e;
    logic [3:0] exp_oh, exp_g;
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL single_idle got=busy want=idle"); end
    req = 4'b0001;
    req_len[7:0] = 8'd3;
    c = cyc;
    sb.push_back('{0, c + 5});
    busy_n = 0;
    done_n = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_g = (k <= 4) ? 4'b0001 : 4'b0000;
      total++; if (grant !== exp_g) begin bad++; $display("FAIL single_grant k=%0d got=%b want=%b", k, grant, exp_g); end
      if (k <= 5) begin
        total++;
        if (cnt_val !== 8'((k <= 4) ? k - 1 : 3)) begin
          bad++; $display("FAIL single_cnt k=%0d got=%0d want=%0d", k, cnt_val, (k <= 4) ? k - 1 : 3);
        end
      end
      if (busy === 1'b1) busy_n++;
      if (done !== 4'h0) begin
        done_n++;
        e = sb.pop_front();
        exp_oh = 4'b0001 << e.idx;
        total++;
        if (done !== exp_oh || cyc != e.cyc) begin
          bad++; $display("FAIL single_done got=%b@%0d want=%b@%0d", done, cyc, exp_oh, e.cyc);
        end
        req = 4'h0;
      end
    end
    total++; if (busy_n != 5) begin bad++; $display("FAIL single_busy_cycles got=%0d want=5", busy_n); end
    total++; if (done_n != 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", done_n); end
  endtask

  task automatic test_round_robin();
    int c, grant_n, done_n;
    bit oh_bad;
    exp_t e;
    logic [3:0] exp_oh;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req = 4'hF;
    set_all_len(8'd2);
    c = cyc;
    for (int i = 0; i < 5; i++) sb.push_back('{i % 4, c + 4 + 5 * i});
    grant_n = 0;
    done_n = 0;
    oh_bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (grant !== 4'h0) grant_n++;
      if (!$onehot0(grant) || !$onehot0(done)) oh_bad = 1'b1;
      if (done !== 4'h0) begin
        done_n++;
        e = sb.pop_front();
        exp_oh = 4'b0001 << e.idx;
        total++;
        if (done !== exp_oh || cyc != e.cyc) begin
          bad++; $display("FAIL rr_done got=%b@%0d want=%b@%0d", done, cyc, exp_oh, e.cyc);
        end
        if (done_n == 5) req = 4'h0;
      end
    end
    total++; if (grant_n != 15) begin bad++; $display("FAIL rr_grant_cycles got=%0d want=15", grant_n); end
    total++; if (done_n != 5) begin bad++; $display("FAIL rr_done_count got=%0d want=5", done_n); end
    total++; if (oh_bad) begin bad++; $display("FAIL rr_onehot got=multi want=onehot0"); end
  endtask

  task automatic test_zero_len();
    int c, done_n;
    bit ok;
    exp_t e;
    logic [3:0] exp_oh;
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL zero_idle got=busy want=idle"); end
    req = 4'b0100;
    req_len[23:16] = 8'd0;
    c = cyc;
    sb.push_back('{2, c + 2});
    done_n = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k <= 2) begin
        total++;
        if (busy !== 1'b1 || cnt_val !== 8'd0) begin
          bad++; $display("FAIL zero_state k=%0d got=busy%b/cnt%0d want=busy1/cnt0", k, busy, cnt_val);
        end
      end
      if (k == 1) begin
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL zero_grant got=%b want=0100", grant); end
      end
      if (done !== 4'h0) begin
        done_n++;
        e = sb.pop_front();
        exp_oh = 4'b0001 << e.idx;
        total++;
        if (done !== exp_oh || cyc != e.cyc) begin
          bad++; $display("FAIL zero_done got=%b@%0d want=%b@%0d", done, cyc, exp_oh, e.cyc);
        end
        req = 4'h0;
      end
    end
    total++; if (done_n != 1) begin bad++; $display("FAIL zero_done_count got=%0d want=1", done_n); end
  endtask

  task automatic test_max_len();
    int c, done_n, max_c;
    bit ok, nonmono;
    logic [7:0] prev;
    exp_t e;
    logic [3:0] exp_oh;
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL max_idle got=busy want=idle"); end
    req = 4'b0010;
    req_len[15:8] = 8'hFF;
    c = cyc;
    sb.push_back('{1, c + 257});
    done_n = 0;
    max_c = 0;
    nonmono = 1'b0;
    prev = 8'd0;
    for (int k = 1; k <= 262; k++) begin
      @(negedge clk);
      if (k == 30) set_all_len(8'h10);
      if (busy === 1'b1 && k >= 2) begin
        if (cnt_val < prev) nonmono = 1'b1;
      end
      prev = cnt_val;
      if (int'(cnt_val) > max_c) max_c = int'(cnt_val);
      if (done !== 4'h0) begin
        done_n++;
        e = sb.pop_front();
        exp_oh = 4'b0001 << e.idx;
        total++;
        if (done !== exp_oh || cyc != e.cyc || cnt_val !== 8'hFF) begin
          bad++; $display("FAIL max_done got=%b@%0d cnt=%0d want=%b@%0d cnt=255", done, cyc, cnt_val, exp_oh, e.cyc);
        end
        req = 4'h0;
      end
    end
    total++; if (max_c != 255) begin bad++; $display("FAIL max_peak got=%0d want=255", max_c); end
    total++; if (nonmono) begin bad++; $display("FAIL max_wrap got=decrease want=monotonic"); end
    total++; if (done_n != 1) begin bad++; $display("FAIL max_done_count got=%0d want=1", done_n); end
  endtask

  task automatic test_reset_mid_run();
    bit ok, hit;
    int done_n;
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_run_idle got=busy want=idle"); end
    req = 4'b0001;
    set_all_len(8'd20);
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (busy === 1'b1 && cnt_val === 8'd5) hit = 1'b1;
    end
    total++; if (!hit) begin bad++; $display("FAIL rst_run_reach got=cnt%0d want=cnt5", cnt_val); end
    reset = 1'b1;
    #1;
    total++; if (grant !== 4'h0) begin bad++; $display("FAIL rst_run_grant got=%b want=0000", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_run_busy got=%b want=0", busy); end
    total++; if (cnt_val !== 8'd0) begin bad++; $display("FAIL rst_run_cnt got=%0d want=0", cnt_val); end
    req = 4'h0;
    done_n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) reset = 1'b0;
      if (done !== 4'h0) done_n++;
    end
    total++; if (done_n != 0) begin bad++; $display("FAIL rst_run_no_done got=%0d want=0", done_n); end
  endtask

  task automatic test_abort();
    int c, done_n;
    bit ok, hit;
    exp_t e;
    logic [3:0] exp_oh;
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_idle got=busy want=idle"); end
    req = 4'b0001;
    set_all_len(8'd10);
    c = cyc;
`ifndef TIMER_SCHED_ABORT_EN
    sb.push_back('{0, c + 12});
`endif
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      if (busy === 1'b1 && cnt_val === 8'd5) hit = 1'b1;
    end
    total++; if (!hit) begin bad++; $display("FAIL abort_reach got=cnt%0d want=cnt5", cnt_val); end
    req = 4'h0;
    done_n = 0;
`ifdef TIMER_SCHED_ABORT_EN
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || grant !== 4'h0 || cnt_val !== 8'd0) begin
      bad++; $display("FAIL abort_state got=busy%b/grant%b/cnt%0d want=0/0000/0", busy, grant, cnt_val);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done !== 4'h0) done_n++;
    end
    total++; if (done_n != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", done_n); end
`else
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done !== 4'h0) begin
        done_n++;
        e = sb.pop_front();
        exp_oh = 4'b0001 << e.idx;
        total++;
        if (done !== exp_oh || cyc != e.cyc) begin
          bad++; $display("FAIL abort_ignored_done got=%b@%0d want=%b@%0d", done, cyc, exp_oh, e.cyc);
        end
      end
    end
    total++; if (done_n != 1) begin bad++; $display("FAIL abort_ignored_count got=%0d want=1", done_n); end
`endif
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    cyc     = 0;
    reset   = 1'b1;
    req     = 4'h0;
    req_len = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_max_len();
    test_reset_mid_run();
    test_abort();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
